// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: byte width, baud divider and the transmit-drain FSM states.
package uart_tx_fifo_pkg;

    localparam int UART_BYTE_W    = 8;
    localparam int DIV_115200_27M = 233;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered count and flags.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int WIDTH = UART_BYTE_W,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      next_wr_ptr;
    logic [AW:0]      next_rd_ptr;
    logic [AW:0]      next_count;
    logic             do_write;
    logic             do_read;

    // Full blocks a write even when a pop happens in the same cycle.
    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    always_comb begin
        next_wr_ptr = wr_ptr;
        next_rd_ptr = rd_ptr;
        if (do_write) next_wr_ptr = wr_ptr + (AW+1)'(1);
        if (do_read)  next_rd_ptr = rd_ptr + (AW+1)'(1);
        next_count = next_wr_ptr - next_rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= next_wr_ptr;
            rd_ptr <= next_rd_ptr;
            count  <= next_count;
            full   <= (next_count == (AW+1)'(DEPTH));
            empty  <= (next_count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx: queues producer bytes and drains them one frame at a time.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   uart_clk,
    input  logic                   uart_rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [AW:0]            fifo_count,
    output logic                   overflow,
    input  logic                   overflow_clr,
    output logic                   tx_idle,
    output logic                   uart_tx_start,
    output logic [UART_BYTE_W-1:0] uart_tx_data,
    input  logic                   uart_tx_busy
);

    tx_state_t              state;
    logic [UART_BYTE_W-1:0] head;
    logic                   pop;

    assign pop = (state == IDLE) && !fifo_empty && !uart_tx_busy;

    sync_fifo #(
        .WIDTH (UART_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (uart_clk),
        .rst     (uart_rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A frame already running in uart_tx survives reset; IDLE only issues once busy is low.
    always_ff @(posedge uart_clk) begin
        if (uart_rst) begin
            state         <= IDLE;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            overflow      <= 1'b0;
        end else begin
            if (wr_en && fifo_full) overflow <= 1'b1;
            else if (overflow_clr)  overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_tx_data  <= head;
                        uart_tx_start <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    if (uart_tx_busy) begin
                        uart_tx_start <= 1'b0;
                        state         <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) state <= IDLE;
                end
                default: begin
                    uart_tx_start <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign tx_idle = fifo_empty && (state == IDLE) && !uart_tx_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a DEPTH=16 instance behind a uart_tx busy model, plus a DEPTH=4 instance.
module tb_uart_tx_fifo;

    localparam int BUSY_LEN = 20;

    logic       clk = 1'b0;
    logic       uart_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;
    logic       tx_idle;
    logic       uart_tx_start;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    logic       f4_wr_en;
    logic [7:0] f4_wr_data;
    logic       f4_full;
    logic       f4_empty;
    logic [2:0] f4_count;
    logic       f4_overflow;
    logic       f4_overflow_clr;
    logic       f4_tx_idle;
    logic       f4_start;
    logic [7:0] f4_data;
    logic       f4_busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] delivered[$];
    logic [7:0] expected[$];
    logic       busy_force_en = 1'b0;
    logic       busy_force_val = 1'b0;
    int         bm_state = 0;
    int         bm_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .uart_clk      (clk),
        .uart_rst      (uart_rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .tx_idle       (tx_idle),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_busy  (uart_tx_busy)
    );

    uart_tx_fifo #(.DEPTH(4)) dut4 (
        .uart_clk      (clk),
        .uart_rst      (uart_rst),
        .wr_en         (f4_wr_en),
        .wr_data       (f4_wr_data),
        .fifo_full     (f4_full),
        .fifo_empty    (f4_empty),
        .fifo_count    (f4_count),
        .overflow      (f4_overflow),
        .overflow_clr  (f4_overflow_clr),
        .tx_idle       (f4_tx_idle),
        .uart_tx_start (f4_start),
        .uart_tx_data  (f4_data),
        .uart_tx_busy  (f4_busy)
    );

    // uart_tx stand-in: busy rises 2 cycles after start is seen, stays high BUSY_LEN cycles, logs the byte.
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy_force_en) begin
                uart_tx_busy = busy_force_val;
                bm_state = 0;
            end else begin
                case (bm_state)
                    0: begin
                        uart_tx_busy = 1'b0;
                        if (uart_tx_start) begin
                            bm_cnt = 1;
                            bm_state = 1;
                        end
                    end
                    1: begin
                        if (bm_cnt == 0) begin
                            uart_tx_busy = 1'b1;
                            delivered.push_back(uart_tx_data);
                            bm_cnt = BUSY_LEN - 1;
                            bm_state = 2;
                        end else bm_cnt--;
                    end
                    default: begin
                        if (bm_cnt == 0) begin
                            uart_tx_busy = 1'b0;
                            bm_state = 0;
                        end else bm_cnt--;
                    end
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic [7:0] data, input logic clr);
        wr_en = en;
        wr_data = data;
        overflow_clr = clr;
    endtask

    task automatic wait_tx_idle(input string tag, input int limit);
        int n = 0;
        while (!tx_idle && n < limit) begin
            tick();
            n++;
        end
        check_output(tag, {31'd0, tx_idle}, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        logic [31:0] got;
        check_output({tag, "_len"}, delivered.size(), expected.size());
        for (int i = 0; i < expected.size(); i++) begin
            got = (i < delivered.size()) ? {24'd0, delivered[i]} : 32'hDEAD_0000 + i;
            check_output(tag, got, {24'd0, expected[i]});
        end
        delivered.delete();
        expected.delete();
    endtask

    initial begin
        string hello;
        logic [7:0] b;
        hello = "Hello\r\n";
        uart_rst = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        f4_wr_en = 1'b0;
        f4_wr_data = 8'h00;
        f4_overflow_clr = 1'b0;
        f4_busy = 1'b0;

        repeat (2) tick();
        check_output("rst_start", {31'd0, uart_tx_start}, 32'd0);
        check_output("rst_data", {24'd0, uart_tx_data}, 32'h00);
        check_output("rst_overflow", {31'd0, overflow}, 32'd0);
        check_output("rst_count", {27'd0, fifo_count}, 32'd0);
        check_output("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check_output("rst_full", {31'd0, fifo_full}, 32'd0);
        check_output("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check_output("rst_f4_count", {29'd0, f4_count}, 32'd0);
        uart_rst = 1'b0;

        $display("[TB] idle after reset");
        repeat (8) begin
            tick();
            check_output("idle_start", {31'd0, uart_tx_start}, 32'd0);
        end
        check_output("idle_empty", {31'd0, fifo_empty}, 32'd1);
        check_output("idle_count", {27'd0, fifo_count}, 32'd0);
        check_output("idle_tx_idle", {31'd0, tx_idle}, 32'd1);

        $display("[TB] single byte 0x41");
        apply_stimulus(1'b1, 8'h41, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("single_n1_empty", {31'd0, fifo_empty}, 32'd0);
        check_output("single_n1_count", {27'd0, fifo_count}, 32'd1);
        check_output("single_n1_start", {31'd0, uart_tx_start}, 32'd0);
        tick();
        check_output("single_n2_start", {31'd0, uart_tx_start}, 32'd1);
        check_output("single_n2_data", {24'd0, uart_tx_data}, 32'h41);
        check_output("single_n2_count", {27'd0, fifo_count}, 32'd0);
        tick();
        check_output("single_n3_start", {31'd0, uart_tx_start}, 32'd1);
        tick();
        check_output("single_n4_start", {31'd0, uart_tx_start}, 32'd1);
        tick();
        check_output("single_n5_start", {31'd0, uart_tx_start}, 32'd0);
        check_output("single_n5_data", {24'd0, uart_tx_data}, 32'h41);
        wait_tx_idle("single_idle", 60);
        expected.push_back(8'h41);
        check_stream("single_stream");

        $display("[TB] burst Hello CR LF");
        for (int i = 0; i < hello.len(); i++) begin
            b = hello[i];
            apply_stimulus(1'b1, b, 1'b0);
            expected.push_back(b);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0);
        wait_tx_idle("burst_idle", 7 * 30);
        check_stream("burst_stream");

        $display("[TB] fill and overflow with busy held high");
        busy_force_en = 1'b1;
        busy_force_val = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0);
            tick();
        end
        check_output("fill_full", {31'd0, fifo_full}, 32'd1);
        check_output("fill_count", {27'd0, fifo_count}, 32'd16);
        check_output("fill_overflow", {31'd0, overflow}, 32'd0);
        check_output("fill_start", {31'd0, uart_tx_start}, 32'd0);
        apply_stimulus(1'b1, 8'h10, 1'b0);
        tick();
        check_output("ovf_set", {31'd0, overflow}, 32'd1);
        check_output("ovf_count", {27'd0, fifo_count}, 32'd16);
        apply_stimulus(1'b1, 8'h11, 1'b1);
        tick();
        check_output("ovf_set_wins", {31'd0, overflow}, 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        tick();
        check_output("ovf_clr", {31'd0, overflow}, 32'd0);
        check_output("ovf_tx_idle", {31'd0, tx_idle}, 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        busy_force_en = 1'b0;
        for (int i = 0; i < 16; i++) expected.push_back(8'(i));
        wait_tx_idle("ovf_drain_idle", 16 * 30);
        check_stream("ovf_stream");

        $display("[TB] reset while in START");
        busy_force_en = 1'b1;
        busy_force_val = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("mid_start", {31'd0, uart_tx_start}, 32'd1);
        check_output("mid_data", {24'd0, uart_tx_data}, 32'hA0);
        check_output("mid_count", {27'd0, fifo_count}, 32'd5);
        uart_rst = 1'b1;
        busy_force_val = 1'b1;
        tick();
        uart_rst = 1'b0;
        check_output("mid_rst_start", {31'd0, uart_tx_start}, 32'd0);
        check_output("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        check_output("mid_rst_empty", {31'd0, fifo_empty}, 32'd1);
        check_output("mid_rst_data", {24'd0, uart_tx_data}, 32'h00);
        repeat (3) begin
            tick();
            check_output("mid_busy_start", {31'd0, uart_tx_start}, 32'd0);
            check_output("mid_busy_tx_idle", {31'd0, tx_idle}, 32'd0);
        end
        busy_force_val = 1'b0;
        tick();
        repeat (5) begin
            tick();
            check_output("mid_quiet_start", {31'd0, uart_tx_start}, 32'd0);
            check_output("mid_quiet_tx_idle", {31'd0, tx_idle}, 32'd1);
        end
        busy_force_en = 1'b0;
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        tick();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("post_rst_n1_start", {31'd0, uart_tx_start}, 32'd0);
        tick();
        check_output("post_rst_n2_start", {31'd0, uart_tx_start}, 32'd1);
        check_output("post_rst_n2_data", {24'd0, uart_tx_data}, 32'h5A);
        wait_tx_idle("post_rst_idle", 60);
        expected.push_back(8'h5A);
        check_stream("post_rst_stream");

        // Depth-4 instance: each new push lands on the pop edge, so count stays at 1 through 10 wraps.
        $display("[TB] depth 4 push on pop cycles");
        f4_wr_en = 1'b1;
        f4_wr_data = 8'd3;
        tick();
        for (int i = 1; i < 40; i++) begin
            check_output("f4_pre_count", {29'd0, f4_count}, 32'd1);
            check_output("f4_pre_start", {31'd0, f4_start}, 32'd0);
            f4_wr_en = 1'b1;
            f4_wr_data = 8'(i * 7 + 3);
            tick();
            f4_wr_en = 1'b0;
            check_output("f4_pop_start", {31'd0, f4_start}, 32'd1);
            check_output("f4_pop_data", {24'd0, f4_data}, 32'((i - 1) * 7 + 3) & 32'hFF);
            check_output("f4_pop_count", {29'd0, f4_count}, 32'd1);
            f4_busy = 1'b1;
            tick();
            check_output("f4_busy_start", {31'd0, f4_start}, 32'd0);
            f4_busy = 1'b0;
            tick();
        end
        tick();
        check_output("f4_last_start", {31'd0, f4_start}, 32'd1);
        check_output("f4_last_data", {24'd0, f4_data}, 32'(39 * 7 + 3) & 32'hFF);
        check_output("f4_last_count", {29'd0, f4_count}, 32'd0);
        f4_busy = 1'b1;
        tick();
        f4_busy = 1'b0;
        tick();
        tick();
        check_output("f4_end_tx_idle", {31'd0, f4_tx_idle}, 32'd1);
        check_output("f4_end_overflow", {31'd0, f4_overflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
